// File: rtl/mem_responder_pkg.sv
// Shared types for the mem_responder memory model.
package mem_responder_pkg;

    localparam int unsigned CountW = 4;

    typedef struct packed {
        logic [31:0]       rdata;
        logic              err;
        logic [CountW-1:0] count;
    } resp_entry_t;

endpackage

// File: rtl/mem_responder_fifo.sv
// In-order response FIFO; every resident entry counts down to zero and the head
// is presented (and popped) once its count is zero.
module mem_responder_fifo
    import mem_responder_pkg::*;
#(
    parameter int unsigned Entries = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  resp_entry_t i_push_entry,
    output logic        o_full,
    output logic        o_pop,
    output logic [31:0] o_head_rdata,
    output logic        o_head_err
);

    localparam int unsigned PtrW = (Entries > 1) ? $clog2(Entries) : 1;
    localparam int unsigned OccW = $clog2(Entries + 1);

    resp_entry_t     r_ent [Entries];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [OccW-1:0] r_occ;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Entries - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Pop depends only on registered state, so the grant path may use it freely.
    assign o_pop        = (r_occ != '0) && (r_ent[r_rptr].count == '0);
    assign o_full       = (r_occ == OccW'(Entries));
    assign o_head_rdata = r_ent[r_rptr].rdata;
    assign o_head_err   = r_ent[r_rptr].err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (i_push) r_wptr <= next_ptr(r_wptr);
            if (o_pop)  r_rptr <= next_ptr(r_rptr);
            case ({i_push, o_pop})
                2'b10:   r_occ <= r_occ + OccW'(1);
                2'b01:   r_occ <= r_occ - OccW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < Entries; i++) begin
            if (i_push && (r_wptr == PtrW'(i))) begin
                r_ent[i] <= i_push_entry;
            end else if (r_ent[i].count != '0) begin
                r_ent[i].count <= r_ent[i].count - CountW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder with grant stalling and in-order delayed responses.
// Define MEM_RESPONDER_ADDR_ERR_EN to return error responses for out-of-window accesses.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned Depth          = 1024,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] AddrBase       = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic [3:0]  gnt_stall_i,
    input  logic [3:0]  resp_lat_i
);

    localparam int unsigned IdxW = $clog2(Depth);

    logic [31:0]       r_mem [Depth];
    logic [CountW-1:0] r_stall;

    logic [31:0]       w_word;
    logic [IdxW-1:0]   w_idx;
    logic              w_err;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic [31:0]       w_head_rdata;
    logic              w_head_err;
    resp_entry_t       w_push_entry;

    assign w_word = (addr_i - AddrBase) >> 2;
    assign w_idx  = IdxW'(w_word);

`ifdef MEM_RESPONDER_ADDR_ERR_EN
    assign w_err = (w_word >= Depth);
`else
    assign w_err = 1'b0;
`endif

    // The counter parks at the stall value while the FIFO is full, so ">=" behaves
    // as "==" in normal use and cannot overshoot if the stall input is lowered.
    assign gnt_o   = req_i && !rst_i && (r_stall >= gnt_stall_i) && (!w_full || w_pop);
    assign w_wr_en = gnt_o && we_i && !w_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall <= '0;
        end else if (!req_i || gnt_o) begin
            r_stall <= '0;
        end else if (r_stall < gnt_stall_i) begin
            r_stall <= r_stall + CountW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_push_entry.rdata = (we_i || w_err) ? '0 : r_mem[w_idx];
        w_push_entry.err   = w_err;
        w_push_entry.count = resp_lat_i;
    end

    mem_responder_fifo #(
        .Entries(MaxOutstanding)
    ) u_fifo (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_push      (gnt_o),
        .i_push_entry(w_push_entry),
        .o_full      (w_full),
        .o_pop       (w_pop),
        .o_head_rdata(w_head_rdata),
        .o_head_err  (w_head_err)
    );

    assign rvalid_o = w_pop;
    assign rdata_o  = w_pop ? w_head_rdata : '0;
    assign err_o    = w_pop && w_head_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed tables and sequences plus random
// traffic against a due-time based reference model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned MAXO  = 2;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [3:0]  gnt_stall_i;
    logic [3:0]  resp_lat_i;

    always #5 clk_i = ~clk_i;

    mem_responder #(
        .Depth         (DEPTH),
        .MaxOutstanding(MAXO),
        .AddrBase      (BASE)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .gnt_stall_i(gnt_stall_i),
        .resp_lat_i (resp_lat_i)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } vec_t;

    exp_t        mq[$];
    logic [31:0] mem_m [DEPTH];
    int          cyc;
    int          held;
    int          last_due;
    int          checks;
    int          errors;
    logic        l_gnt;
    logic        l_rv;
    logic        l_err;
    logic [31:0] l_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_push();
        exp_t        e;
        logic [31:0] word;
        int unsigned idx;
        int          earliest;
        word = (addr_i - BASE) >> 2;
        idx  = word % DEPTH;
`ifdef MEM_RESPONDER_ADDR_ERR_EN
        e.err = (word >= DEPTH);
`else
        e.err = 1'b0;
`endif
        e.rdata  = (we_i || e.err) ? 32'h0 : mem_m[idx];
        earliest = cyc + int'(resp_lat_i) + 1;
        e.due    = (earliest > last_due + 1) ? earliest : last_due + 1;
        last_due = e.due;
        mq.push_back(e);
        if (we_i && !e.err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_m[idx][8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    endtask

    // One clock cycle: compare outputs mid-cycle with the model, then advance.
    task automatic step();
        logic        e_rv;
        logic        e_gnt;
        logic        e_err;
        logic [31:0] e_rd;
        logic        room;
        #3;
        e_rv  = (mq.size() > 0) && (mq[0].due == cyc);
        e_rd  = e_rv ? mq[0].rdata : 32'h0;
        e_err = e_rv ? mq[0].err : 1'b0;
        room  = (mq.size() < int'(MAXO)) || e_rv;
        e_gnt = req_i && (held >= int'(gnt_stall_i)) && room;
        l_gnt = gnt_o;
        l_rv  = rvalid_o;
        l_rd  = rdata_o;
        l_err = err_o;
        check("gnt", {31'h0, gnt_o}, {31'h0, e_gnt});
        check("rvalid", {31'h0, rvalid_o}, {31'h0, e_rv});
        check("rdata", rdata_o, e_rd);
        check("err", {31'h0, err_o}, {31'h0, e_err});
        if (e_rv) void'(mq.pop_front());
        if (e_gnt) model_push();
        held = (!req_i || e_gnt) ? 0 : held + 1;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output int waited);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        be_i    = be;
        wdata_i = wd;
        waited  = 0;
        step();
        while (!l_gnt && waited < 40) begin
            waited++;
            step();
        end
        if (!l_gnt) check("gnt_timeout", 32'h0, 32'h1);
        req_i = 1'b0;
    endtask

    task automatic wait_rv(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!l_rv && k < 40);
        if (!l_rv) check("rvalid_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        vec_t        tbl[9];
        logic [31:0] init_vals[16];
        logic [31:0] a37[3];
        logic [31:0] d37_exp[3];
        int          g37[3];
        int          r37[3];
        logic [31:0] d37[3];
        int          ni;
        int          nr;
        int          w;
        int          k;
        int          rv_after_rst;

        checks = 0;
        errors = 0;

        tbl[0] = '{1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h10, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 32'h20, 4'h5, 32'h11223344, 1'b1, 1'b1, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h20, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'hFF22FF44};
        tbl[8] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b0, 32'h0};

        a37     = '{32'h10, 32'h20, 32'h10};
        d37_exp = '{32'hDEADBEEF, 32'hFF22FF44, 32'hDEADBEEF};

        rst_i       = 1'b1;
        req_i       = 1'b0;
        we_i        = 1'b0;
        addr_i      = '0;
        be_i        = '0;
        wdata_i     = '0;
        gnt_stall_i = '0;
        resp_lat_i  = '0;

        // Reset state, including grant masked while reset is held.
        @(posedge clk_i);
        #1;
        req_i = 1'b1;
        #1;
        check("rst_gnt", {31'h0, gnt_o}, 32'h0);
        check("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        cyc      = 0;
        held     = 0;
        last_due = -1;

        // Give the low 16 words known contents.
        for (int i = 0; i < 16; i++) begin
            init_vals[i] = $urandom;
            issue(1'b1, BASE + 32'(4 * i), 4'hF, init_vals[i], w);
        end
        for (int i = 0; i < 3; i++) step();

        // Zero stall / zero latency write-read and partial byte-enable write.
        for (int i = 0; i < 9; i++) begin
            req_i   = tbl[i].req;
            we_i    = tbl[i].we;
            addr_i  = tbl[i].addr;
            be_i    = tbl[i].be;
            wdata_i = tbl[i].wdata;
            step();
            check($sformatf("tbl%0d_gnt", i), {31'h0, l_gnt}, {31'h0, tbl[i].gnt});
            check($sformatf("tbl%0d_rvalid", i), {31'h0, l_rv}, {31'h0, tbl[i].rvalid});
            check($sformatf("tbl%0d_rdata", i), l_rd, tbl[i].rdata);
        end
        req_i = 1'b0;

        // Stall 3, latency 2.
        gnt_stall_i = 4'd3;
        resp_lat_i  = 4'd2;
        issue(1'b0, 32'h10, 4'h0, 32'h0, w);
        check("stall3_wait", 32'(w), 32'd3);
        wait_rv(k);
        check("lat2_rvalid_delay", 32'(k), 32'd3);
        check("lat2_rdata", l_rd, 32'hDEADBEEF);

        // Back-to-back reads against a two-entry FIFO with latency 5.
        gnt_stall_i = 4'd0;
        resp_lat_i  = 4'd5;
        ni = 0;
        nr = 0;
        g37 = '{0, 0, 0};
        r37 = '{0, 0, 0};
        d37 = '{32'h0, 32'h0, 32'h0};
        for (int c = 0; c < 40 && nr < 3; c++) begin
            req_i  = (ni < 3);
            we_i   = 1'b0;
            addr_i = (ni < 3) ? a37[ni] : 32'h0;
            step();
            if (l_gnt && ni < 3) begin
                g37[ni] = cyc - 1;
                ni++;
            end
            if (l_rv && nr < 3) begin
                r37[nr] = cyc - 1;
                d37[nr] = l_rd;
                nr++;
            end
        end
        req_i = 1'b0;
        check("full_rsp_count", 32'(nr), 32'd3);
        check("full_gnt1_gap", 32'(g37[1] - g37[0]), 32'd1);
        check("full_rv0_lat", 32'(r37[0] - g37[0]), 32'd6);
        check("full_gnt2_at_rv0", 32'(g37[2]), 32'(r37[0]));
        check("full_rv1_order", 32'(r37[1] - r37[0]), 32'd1);
        check("full_rv2_lat", 32'(r37[2] - g37[2]), 32'd6);
        for (int i = 0; i < 3; i++) check($sformatf("full_rdata%0d", i), d37[i], d37_exp[i]);

        // Read one word past the end of the window.
        resp_lat_i = 4'd1;
        issue(1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0, w);
        wait_rv(k);
        check("oow_delay", 32'(k), 32'd2);
`ifdef MEM_RESPONDER_ADDR_ERR_EN
        check("oow_err", {31'h0, l_err}, 32'h1);
        check("oow_rdata", l_rd, 32'h0);
`else
        check("oow_err", {31'h0, l_err}, 32'h0);
        check("oow_rdata", l_rd, init_vals[0]);
`endif

        // Reset with two reads outstanding.
        resp_lat_i = 4'd8;
        issue(1'b0, 32'h10, 4'h0, 32'h0, w);
        issue(1'b0, 32'h20, 4'h0, 32'h0, w);
        rst_i = 1'b1;
        req_i = 1'b1;
        #2;
        check("midrst_gnt", {31'h0, gnt_o}, 32'h0);
        check("midrst_rvalid", {31'h0, rvalid_o}, 32'h0);
        req_i = 1'b0;
        mq.delete();
        held     = 0;
        last_due = -1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc++;
        rv_after_rst = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (l_rv) rv_after_rst++;
        end
        check("midrst_no_rvalid", 32'(rv_after_rst), 32'd0);
        resp_lat_i = 4'd0;
        issue(1'b0, 32'h10, 4'h0, 32'h0, w);
        wait_rv(k);
        check("midrst_mem_kept", l_rd, 32'hDEADBEEF);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            req_i = ($urandom_range(0, 9) < 7);
            if (!req_i && $urandom_range(0, 3) == 0) gnt_stall_i = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) resp_lat_i = 4'($urandom_range(0, 6));
            a = 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'(4 * DEPTH);
            we_i    = $urandom_range(0, 1) == 1;
            addr_i  = BASE + a;
            be_i    = 4'($urandom);
            wdata_i = $urandom;
            step();
        end
        req_i = 1'b0;
        for (int i = 0; i < 60; i++) step();
        check("drain_empty", 32'(mq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
